reg_alu_sequencer: RTL

Multi-cycle micro-sequencer that fetches 16-bit instructions from an external instruction memory and drives the control inputs of the register-file/ALU datapath: RA1, RA2, WA, immediate, ALUControl, ALUSrc and write_enable.
- Keeps a program counter and a zero flag sampled from the datapath Zero output.
- Supports conditional branch and halt.
- Sits directly above the reg-file/ALU datapath.
- Started by a one-cycle start pulse from the testbench or top level.

---
 rtl/reg_alu_seq_pkg.sv | 31 +++
 rtl/reg_alu_seq_decode.sv | 57 +++++
 rtl/reg_alu_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/reg_alu_seq_pkg.sv
// Shared types for the reg/ALU micro-sequencer: FSM states, opcodes and
// the 16-bit instruction layout.
package reg_alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALU_R = 4'h4;
  localparam logic [3:0] OP_ALU_I = 4'h8;
  localparam logic [3:0] OP_BZ    = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] wa;
    logic [3:0] ra1;
    logic [3:0] ra2;
  } instr_t;

  // imm8 overlays the ra1/ra2 fields.
  function automatic logic [7:0] instr_imm8(instr_t ir);
    return {ir.ra1, ir.ra2};
  endfunction

endpackage

// File: rtl/reg_alu_seq_decode.sv
// Combinational map from the latched instruction to datapath controls and
// opcode class flags.
module reg_alu_seq_decode
  import reg_alu_seq_pkg::*;
#(
  parameter int RF_AW  = 4,
  parameter int DATA_W = 8
) (
  input  instr_t             ir_i,
  output logic [RF_AW-1:0]   ra1_o,
  output logic [RF_AW-1:0]   ra2_o,
  output logic [RF_AW-1:0]   wa_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic [1:0]         alu_ctrl_o,
  output logic               alu_src_o,
  output logic               is_alu_o,
  output logic               is_bz_o,
  output logic               is_halt_o,
  output logic               is_illegal_o
);

  always_comb begin
    ra1_o        = '0;
    ra2_o        = '0;
    wa_o         = '0;
    imm_o        = '0;
    alu_ctrl_o   = 2'b00;
    alu_src_o    = 1'b0;
    is_alu_o     = 1'b0;
    is_bz_o      = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;

    if (ir_i.op[3:2] == OP_ALU_R[3:2]) begin
      is_alu_o   = 1'b1;
      alu_ctrl_o = ir_i.op[1:0];
      ra1_o      = RF_AW'(ir_i.ra1);
      ra2_o      = RF_AW'(ir_i.ra2);
      wa_o       = RF_AW'(ir_i.wa);
    end else if (ir_i.op[3:2] == OP_ALU_I[3:2]) begin
      // wa doubles as the source register for reg-imm ops
      is_alu_o   = 1'b1;
      alu_ctrl_o = ir_i.op[1:0];
      alu_src_o  = 1'b1;
      ra1_o      = RF_AW'(ir_i.wa);
      wa_o       = RF_AW'(ir_i.wa);
      imm_o      = DATA_W'(instr_imm8(ir_i));
    end else if (ir_i.op == OP_BZ) begin
      is_bz_o = 1'b1;
    end else if (ir_i.op == OP_HALT) begin
      is_halt_o = 1'b1;
    end else if (ir_i.op != OP_NOP) begin
      is_illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/reg_alu_sequencer.sv
// Three-cycle fetch/decode/exec micro-sequencer driving the reg-file/ALU datapath.
// Define REG_ALU_SEQ_STEP_EN to add step_i, which gates each FETCH for single-stepping.
module reg_alu_sequencer
  import reg_alu_seq_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int RF_AW  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
`ifdef REG_ALU_SEQ_STEP_EN
  input  logic              step_i,
`endif
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic [15:0]       imem_data_i,
  output logic [RF_AW-1:0]  ra1_o,
  output logic [RF_AW-1:0]  ra2_o,
  output logic [RF_AW-1:0]  wa_o,
  output logic [DATA_W-1:0] immediate_o,
  output logic [1:0]        alu_control_o,
  output logic              alu_src_o,
  output logic              write_enable_o,
  input  logic              zero_i,
  output logic              busy_o,
  output logic              halted_o,
  output logic              illegal_o
);

  // state    | meaning
  // S_IDLE   | waiting for start after reset
  // S_FETCH  | imem_addr = pc presented to instruction memory
  // S_DECODE | imem_data valid, latched into ir_q at the ending edge
  // S_EXEC   | controls driven, write strobe, zero_flag and pc update
  // S_HALTED | HALT executed, pc parked on the HALT address

  state_e            state_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              zero_flag_q;
  logic              illegal_q;
  logic              busy_q;
  logic              halted_q;
  instr_t            ir_q;

  logic is_alu, is_bz, is_halt, is_illegal;
  logic fetch_go;

`ifdef REG_ALU_SEQ_STEP_EN
  assign fetch_go = step_i;
`else
  assign fetch_go = 1'b1;
`endif

  reg_alu_seq_decode #(
    .RF_AW (RF_AW),
    .DATA_W(DATA_W)
  ) u_decode (
    .ir_i        (ir_q),
    .ra1_o       (ra1_o),
    .ra2_o       (ra2_o),
    .wa_o        (wa_o),
    .imm_o       (immediate_o),
    .alu_ctrl_o  (alu_control_o),
    .alu_src_o   (alu_src_o),
    .is_alu_o    (is_alu),
    .is_bz_o     (is_bz),
    .is_halt_o   (is_halt),
    .is_illegal_o(is_illegal)
  );

  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (is_bz && zero_flag_q) pc_d = PC_W'(instr_imm8(ir_q));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      zero_flag_q <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      ir_q        <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_HALTED: begin
          if (start_i) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            zero_flag_q <= 1'b0;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b1;
            halted_q    <= 1'b0;
          end
        end
        S_FETCH: begin
          if (fetch_go) state_q <= S_DECODE;
        end
        S_DECODE: begin
          ir_q    <= instr_t'(imem_data_i);
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_alu)     zero_flag_q <= zero_i;
          if (is_illegal) illegal_q   <= 1'b1;
          if (is_halt) begin
            state_q  <= S_HALTED;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            pc_q    <= pc_d;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Combinational so an async reset mid-EXEC drops the strobe at once.
  assign write_enable_o = (state_q == S_EXEC) && is_alu;
  assign imem_addr_o    = pc_q;
  assign busy_o         = busy_q;
  assign halted_o       = halted_q;
  assign illegal_o      = illegal_q;

endmodule
